// File: rtl/i2s_serializer.sv
// Stereo I2S transmitter: 64-slot frames, MSB-first with one-bit delay, one-clk ena per frame.
// Optional master clock output built when I2S_MCLK_EN is defined.
module i2s_serializer #(
    parameter int BCLK_DIV = 16,
    parameter int DATA_W   = 24
`ifdef I2S_MCLK_EN
    , parameter int MCLK_DIV = 4
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] l_data,
    input  logic [DATA_W-1:0] r_data,
    output logic              ena,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata
`ifdef I2S_MCLK_EN
    , output logic            mclk
`endif
);
    localparam int              DW       = $clog2(BCLK_DIV);
    localparam logic [DW-1:0]   DIV_MAX  = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0]   DIV_HALF = DW'(BCLK_DIV / 2);
    localparam logic [5:0]      L_LAST   = 6'(DATA_W);
    localparam logic [5:0]      R_FIRST  = 6'd33;
    localparam logic [5:0]      R_LAST   = 6'(32 + DATA_W);

    logic [DW-1:0]     div_q, div_d;
    logic [5:0]        slot_q, slot_d;
    logic              bclk_q, bclk_d;
    logic              lrclk_q, lrclk_d;
    logic              sdata_q, sdata_d;
    logic              ena_q, ena_d;
    logic [DATA_W-1:0] shl_q, shl_d;
    logic [DATA_W-1:0] shr_q, shr_d;
    logic              tick;

    always_comb begin
        tick    = (div_q == DIV_MAX);
        div_d   = tick ? '0 : div_q + 1'b1;
        slot_d  = tick ? slot_q + 6'd1 : slot_q;
        bclk_d  = bclk_q;
        lrclk_d = lrclk_q;
        sdata_d = sdata_q;
        shl_d   = shl_q;
        shr_d   = shr_q;
        ena_d   = 1'b0;
        if (tick)
            bclk_d = 1'b0;
        else if (div_d == DIV_HALF)
            bclk_d = 1'b1;
        // Everything serial moves only on the falling tick, so it is stable at bclk rise.
        if (tick) begin
            lrclk_d = slot_d[5];
            sdata_d = 1'b0;
            if (slot_d == 6'd0) begin
                shl_d = l_data;
                shr_d = r_data;
                ena_d = 1'b1;
            end else if (slot_d <= L_LAST) begin
                sdata_d = shl_q[DATA_W-1];
                shl_d   = shl_q << 1;
            end else if (slot_d >= R_FIRST && slot_d <= R_LAST) begin
                sdata_d = shr_q[DATA_W-1];
                shr_d   = shr_q << 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            slot_q  <= '0;
            bclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
            sdata_q <= 1'b0;
            ena_q   <= 1'b0;
            shl_q   <= '0;
            shr_q   <= '0;
        end else begin
            div_q   <= div_d;
            slot_q  <= slot_d;
            bclk_q  <= bclk_d;
            lrclk_q <= lrclk_d;
            sdata_q <= sdata_d;
            ena_q   <= ena_d;
            shl_q   <= shl_d;
            shr_q   <= shr_d;
        end
    end

    assign ena   = ena_q;
    assign bclk  = bclk_q;
    assign lrclk = lrclk_q;
    assign sdata = sdata_q;

`ifdef I2S_MCLK_EN
    localparam int            MW      = (MCLK_DIV > 2) ? $clog2(MCLK_DIV) : 1;
    localparam logic [MW-1:0] M_MAX   = MW'(MCLK_DIV - 1);
    localparam logic [MW-1:0] M_HALF  = MW'(MCLK_DIV / 2);

    logic [MW-1:0] mcnt_q, mcnt_d;
    logic          mclk_q, mclk_d;

    // Realigned on the bclk wrap so mclk always tracks div mod MCLK_DIV.
    always_comb begin
        mcnt_d = (tick || mcnt_q == M_MAX) ? '0 : mcnt_q + 1'b1;
        mclk_d = (mcnt_d >= M_HALF);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcnt_q <= '0;
            mclk_q <= 1'b0;
        end else begin
            mcnt_q <= mcnt_d;
            mclk_q <= mclk_d;
        end
    end

    assign mclk = mclk_q;
`endif

endmodule

// File: tb/tb_i2s_serializer.sv
// Self-checking bench for i2s_serializer: time-based reference model of the I2S frame
// (derived from clk count since reset release) compared against DUT outputs every cycle.
module tb_i2s_serializer;
    localparam int BD    = 16;
    localparam int DW    = 24;
    localparam int FRAME = 64 * BD;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] l_data = '0;
    logic [DW-1:0] r_data = '0;
    logic          ena, bclk, lrclk, sdata;
`ifdef I2S_MCLK_EN
    logic          mclk;
`endif

    i2s_serializer #(.BCLK_DIV(BD), .DATA_W(DW)) dut (
        .clk    (clk),
        .reset  (reset),
        .l_data (l_data),
        .r_data (r_data),
        .ena    (ena),
        .bclk   (bclk),
        .lrclk  (lrclk),
        .sdata  (sdata)
`ifdef I2S_MCLK_EN
        , .mclk (mclk)
`endif
    );

    always #5 clk = ~clk;

    // Model state: edges since reset release and the samples latched for the current frame.
    int            t = 0;
    logic [DW-1:0] lat_l = '0;
    logic [DW-1:0] lat_r = '0;
    int            errors = 0;
    int            checks = 0;

    task automatic step();
        @(posedge clk);
        if (reset) begin
            t = 0;
            lat_l = '0;
            lat_r = '0;
        end else begin
            t++;
            if (t % FRAME == 0) begin
                lat_l = l_data;
                lat_r = r_data;
            end
        end
        @(negedge clk);
    endtask

    function automatic int slot_now();
        return (t / BD) % 64;
    endfunction

    // {bclk, lrclk, sdata, ena} expected after edge t.
    function automatic logic [3:0] exp_vec();
        int   div, s;
        logic sd;
        div = t % BD;
        s   = slot_now();
        sd  = 1'b0;
        if (s >= 1 && s <= DW)            sd = lat_l[DW - s];
        else if (s >= 33 && s <= 32 + DW) sd = lat_r[32 + DW - s];
        return {div >= BD / 2, s >= 32, sd, (t > 0) && (t % FRAME == 0)};
    endfunction

    task automatic test_reset();
        int first_ena = -1;
        reset  = 1'b1;
        l_data = DW'($urandom) | 24'h800001;
        r_data = DW'($urandom) | 24'h000100;
        repeat (5) begin
            step();
            checks++;
            if ({bclk, lrclk, sdata, ena} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold got=%b want=0000", {bclk, lrclk, sdata, ena});
            end
        end
        reset = 1'b0;
        for (int i = 0; i < FRAME + 2; i++) begin
            step();
            if (ena && first_ena < 0) first_ena = t;
            checks++;
            if ({bclk, lrclk, sdata, ena} !== exp_vec()) begin
                errors++;
                $display("FAIL first_frame t=%0d got=%b want=%b", t, {bclk, lrclk, sdata, ena}, exp_vec());
            end
        end
        checks++;
        if (first_ena != FRAME) begin
            errors++;
            $display("FAIL first_ena_time got=%0d want=%0d", first_ena, FRAME);
        end
    endtask

    task automatic test_pattern(input string nm, input logic [DW-1:0] l, input logic [DW-1:0] r);
        logic [63:0] word = '0;
        logic [63:0] want;
        l_data = l;
        r_data = r;
        do begin
            step();
            checks++;
            if ({bclk, lrclk, sdata, ena} !== exp_vec()) begin
                errors++;
                $display("FAIL %s_lead t=%0d got=%b want=%b", nm, t, {bclk, lrclk, sdata, ena}, exp_vec());
            end
        end while (t % FRAME != 0);
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (t % BD == BD / 2) word[63 - slot_now()] = sdata;
            checks++;
            if ({bclk, lrclk, sdata, ena} !== exp_vec()) begin
                errors++;
                $display("FAIL %s_cycle t=%0d got=%b want=%b", nm, t, {bclk, lrclk, sdata, ena}, exp_vec());
            end
        end
        want = {1'b0, l, 7'b0, 1'b0, r, 7'b0};
        checks++;
        if (word !== want) begin
            errors++;
            $display("FAIL %s_frame got=%h want=%h", nm, word, want);
        end
    endtask

    task automatic test_midframe_change();
        logic [63:0] word = '0;
        logic [DW-1:0] a, b;
        a = DW'($urandom);
        b = ~a;
        l_data = a;
        r_data = 24'h123456;
        do step(); while (t % FRAME != 0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (slot_now() == 10 && i < FRAME) l_data = b;
            if (t % BD == BD / 2) word[63 - slot_now()] = sdata;
            checks++;
            if ({bclk, lrclk, sdata, ena} !== exp_vec()) begin
                errors++;
                $display("FAIL midchange_cycle t=%0d got=%b want=%b", t, {bclk, lrclk, sdata, ena}, exp_vec());
            end
            if (i == FRAME - 1) begin
                checks++;
                if (word !== {1'b0, a, 8'b0, 24'h123456, 7'b0}) begin
                    errors++;
                    $display("FAIL midchange_inflight got=%h want=%h", word, {1'b0, a, 8'b0, 24'h123456, 7'b0});
                end
                word = '0;
            end
        end
        checks++;
        if (word !== {1'b0, b, 8'b0, 24'h123456, 7'b0}) begin
            errors++;
            $display("FAIL midchange_next got=%h want=%h", word, {1'b0, b, 8'b0, 24'h123456, 7'b0});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4 * FRAME; i++) begin
            if ($urandom_range(0, 299) == 0) l_data = DW'($urandom);
            if ($urandom_range(0, 299) == 0) r_data = DW'($urandom);
            step();
            checks++;
            if ({bclk, lrclk, sdata, ena} !== exp_vec()) begin
                errors++;
                $display("FAIL random t=%0d got=%b want=%b", t, {bclk, lrclk, sdata, ena}, exp_vec());
            end
        end
    endtask

    task automatic test_reset_midframe();
        int first_ena = -1;
        l_data = 24'hFFFFFF;
        r_data = 24'hFFFFFF;
        while (slot_now() != 40) step();
        reset = 1'b1;
        step();
        checks++;
        if ({bclk, lrclk, sdata, ena} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset got=%b want=0000", {bclk, lrclk, sdata, ena});
        end
        reset = 1'b0;
        for (int i = 0; i < FRAME + 2; i++) begin
            step();
            if (ena && first_ena < 0) first_ena = t;
            checks++;
            if ({bclk, lrclk, sdata, ena} !== exp_vec()) begin
                errors++;
                $display("FAIL midreset_restart t=%0d got=%b want=%b", t, {bclk, lrclk, sdata, ena}, exp_vec());
            end
        end
        checks++;
        if (first_ena != FRAME) begin
            errors++;
            $display("FAIL midreset_first_ena got=%0d want=%0d", first_ena, FRAME);
        end
    endtask

`ifdef I2S_MCLK_EN
    task automatic test_mclk();
        for (int i = 0; i < 4 * BD; i++) begin
            step();
            checks++;
            if (mclk !== ((t % BD) % 4 >= 2)) begin
                errors++;
                $display("FAIL mclk t=%0d got=%b want=%b", t, mclk, ((t % BD) % 4 >= 2));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pattern("alt", 24'hA5A5A5, 24'h5A5A5A);
        test_pattern("extreme", 24'h800000, 24'h7FFFFF);
        test_midframe_change();
        test_random();
`ifdef I2S_MCLK_EN
        test_mclk();
`endif
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
